// File: rtl/uart_frame_timer_if.sv
// Control/strobe bundle between a UART frame timer and its TX/RX users.
// master drives start/abort/divisor; slave (the timer) drives the timing strobes.
interface uart_frame_timer_if #(
  parameter int CNT_W = 13,
  parameter int IDX_W = 4
);
  logic [CNT_W-1:0] div_in;
  logic             start;
  logic             abort;
  logic             busy;
  logic             bit_mid;
  logic             bit_end;
  logic             ovs_tick;
  logic [IDX_W-1:0] bit_idx;
  logic             frame_done;

  modport master (
    output div_in, start, abort,
    input  busy, bit_mid, bit_end, ovs_tick, bit_idx, frame_done
  );

  modport slave (
    input  div_in, start, abort,
    output busy, bit_mid, bit_end, ovs_tick, bit_idx, frame_done
  );
endinterface

// File: rtl/uart_frame_timer.sv
// UART frame timer: per-bit mid/end strobes and oversampling ticks over FRAME_BITS periods of div_q+1 clocks.
// Latency: busy/cnt valid one clock after start; strobes are decodes of state; no backpressure (start ignored while busy).
module uart_frame_timer #(
  parameter int               CNT_W       = 13,
  parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(433),
  parameter int               FRAME_BITS  = 10,
  parameter int               IDX_W       = 4,
  parameter int               OVS_LOG2    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_frame_timer_if.slave  tmr
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(3);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] sub_q, sub_d;
  logic [CNT_W-1:0] ovs_len_q, ovs_len_d;

  logic             run;
  logic             bit_end;
  logic             last_bit;
  logic             frame_done;
  logic             accept;
  logic             sub_wrap;
  logic [CNT_W-1:0] div_clamp;
  logic [CNT_W:0]   period;
  logic [CNT_W-1:0] ovs_calc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_DEFAULT;
      idx_q     <= '0;
      sub_q     <= '0;
      ovs_len_q <= CNT_W'(1);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      sub_q     <= sub_d;
      ovs_len_q <= ovs_len_d;
    end
  end

  always_comb begin
    run        = (state_q == RUN);
    bit_end    = run && (cnt_q == div_q);
    last_bit   = (idx_q == LAST_IDX);
    frame_done = bit_end && last_bit;
    // A start is honoured when idle or exactly on the closing clock of a frame.
    accept     = tmr.start && (!run || frame_done);
    sub_wrap   = (sub_q == ovs_len_q - CNT_W'(1));

    div_clamp  = (tmr.div_in < DIV_MIN) ? DIV_MIN : tmr.div_in;
    period     = {1'b0, div_clamp} + {{CNT_W{1'b0}}, 1'b1};
    ovs_calc   = CNT_W'(period >> OVS_LOG2);
    if (ovs_calc == '0) begin
      ovs_calc = CNT_W'(1);
    end

    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    idx_d     = idx_q;
    sub_d     = sub_q;
    ovs_len_d = ovs_len_q;

    if (tmr.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      sub_d   = '0;
    end else if (accept) begin
      state_d   = RUN;
      div_d     = div_clamp;
      ovs_len_d = ovs_calc;
      cnt_d     = '0;
      idx_d     = '0;
      sub_d     = '0;
    end else if (run) begin
      if (bit_end) begin
        // Sub counter resyncs every bit so a truncated tail never ticks.
        cnt_d = '0;
        sub_d = '0;
        if (last_bit) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        sub_d = sub_wrap ? '0 : sub_q + CNT_W'(1);
      end
    end
  end

  assign tmr.busy       = run;
  assign tmr.bit_mid    = run && (cnt_q == (div_q >> 1));
  assign tmr.bit_end    = bit_end;
  assign tmr.ovs_tick   = run && sub_wrap && !bit_end;
  assign tmr.bit_idx    = idx_q;
  assign tmr.frame_done = frame_done;

endmodule

// File: tb/tb_uart_frame_timer.sv
// Randomised bench for uart_frame_timer against a frame-time reference model.
// The model tracks elapsed clocks since frame start and derives every strobe arithmetically.
module tb_uart_frame_timer;
  localparam int FRAME_BITS = 10;

  logic clk;
  logic rst_n;

  uart_frame_timer_if #(.CNT_W(13), .IDX_W(4)) u ();

  uart_frame_timer #(
    .CNT_W(13), .DIV_DEFAULT(13'd433), .FRAME_BITS(FRAME_BITS), .IDX_W(4), .OVS_LOG2(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .tmr  (u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame active flag, clocks elapsed in frame, latched divisor.
  bit m_busy = 1'b0;
  int m_t    = 0;
  int m_d    = 433;

  // Observed pulse counters, cleared by each test.
  int obs_mid, obs_end, obs_tick, obs_done, obs_busy_low;

  task automatic clear_obs();
    obs_mid = 0; obs_end = 0; obs_tick = 0; obs_done = 0; obs_busy_low = 0;
  endtask

  task automatic model_expect(output bit eb, output bit em, output bit ee,
                              output bit et, output bit ed, output int ei);
    int p, c, l;
    eb = m_busy; em = 0; ee = 0; et = 0; ed = 0; ei = 0;
    if (m_busy) begin
      p  = m_d + 1;
      c  = m_t % p;
      ei = m_t / p;
      em = (c == m_d / 2);
      ee = (c == m_d);
      l  = p / 16;
      if (l < 1) l = 1;
      et = ((c % l) == l - 1) && !ee;
      ed = ee && (ei == FRAME_BITS - 1);
    end
  endtask

  task automatic model_update(input bit s, input bit a, input int dv);
    bit eb, em, ee, et, ed;
    int ei;
    model_expect(eb, em, ee, et, ed, ei);
    if (a) begin
      m_busy = 1'b0;
    end else if (s && (!m_busy || ed)) begin
      m_busy = 1'b1;
      m_d    = (dv < 3) ? 3 : dv;
      m_t    = 0;
    end else if (m_busy) begin
      if (ed) m_busy = 1'b0;
      else    m_t++;
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then apply inputs for the next edge.
  task automatic cycle(input bit s, input bit a, input int dv);
    bit eb, em, ee, et, ed;
    int ei;
    logic [3:0] ei4;
    @(negedge clk);
    model_expect(eb, em, ee, et, ed, ei);
    ei4 = ei[3:0];
    vectors++;
    if ({u.busy, u.bit_mid, u.bit_end, u.ovs_tick, u.frame_done, u.bit_idx} !==
        {eb, em, ee, et, ed, ei4}) begin
      miscompares++;
      $display("FAIL cycle @%0t busy/mid/end/ovs/done/idx got %b%b%b%b%b/%0d exp %b%b%b%b%b/%0d",
               $time, u.busy, u.bit_mid, u.bit_end, u.ovs_tick, u.frame_done, u.bit_idx,
               eb, em, ee, et, ed, ei4);
    end
    obs_mid  += int'(u.bit_mid);
    obs_end  += int'(u.bit_end);
    obs_tick += int'(u.ovs_tick);
    obs_done += int'(u.frame_done);
    obs_busy_low += int'(!u.busy);
    u.start  = s;
    u.abort  = a;
    u.div_in = dv[12:0];
    @(posedge clk);
    model_update(s, a, dv);
  endtask

  task automatic check_count(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    int r;
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      u.start  = 1'($urandom);
      u.abort  = 1'($urandom);
      u.div_in = 13'($urandom);
      @(negedge clk);
      vectors++;
      if ({u.busy, u.bit_mid, u.bit_end, u.ovs_tick, u.frame_done, u.bit_idx} !== 9'd0) begin
        miscompares++;
        $display("FAIL reset_hold got %b%b%b%b%b/%0d exp 00000/0", u.busy, u.bit_mid,
                 u.bit_end, u.ovs_tick, u.frame_done, u.bit_idx);
      end
    end
    u.start = 1'b0; u.abort = 1'b0;
    rst_n = 1'b1;
    m_busy = 1'b0;
    clear_obs();
    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 9);
      cycle(1'b0, r == 0, $urandom_range(0, 8191));
    end
    check_count("idle_busy_low", obs_busy_low, 1000);
  endtask

  task automatic test_basic();
    cycle(1'b1, 1'b0, 9);
    clear_obs();
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0, $urandom_range(0, 8191));
    check_count("basic_mid", obs_mid, 10);
    check_count("basic_end", obs_end, 10);
    check_count("basic_done", obs_done, 1);
    check_count("basic_busy_low", obs_busy_low, 0);
    clear_obs();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 9);
    check_count("basic_idle_after", obs_busy_low, 5);
  endtask

  task automatic test_clamp_latch();
    cycle(1'b1, 1'b0, 1);
    clear_obs();
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, (i < 6) ? 1 : 20);
    check_count("clamp_end", obs_end, 10);
    check_count("clamp_done", obs_done, 1);
    clear_obs();
    cycle(1'b0, 1'b0, 20);
    check_count("clamp_idle", obs_busy_low, 1);
  endtask

  task automatic test_back_to_back();
    bit eb, em, ee, et, ed;
    int ei;
    bit restarted = 1'b0;
    cycle(1'b1, 1'b0, 9);
    clear_obs();
    for (int i = 0; i < 155; i++) begin
      model_expect(eb, em, ee, et, ed, ei);
      if (ed && !restarted) begin
        cycle(1'b1, 1'b0, 5);
        restarted = 1'b1;
      end else if (i == 33 || i == 120) begin
        cycle(1'b1, 1'b0, 20);
      end else begin
        cycle(1'b0, 1'b0, 5);
      end
    end
    check_count("b2b_busy_low", obs_busy_low, 0);
    check_count("b2b_done", obs_done, 1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 5);
    check_count("b2b_done_total", obs_done, 2);
  endtask

  task automatic test_abort();
    cycle(1'b1, 1'b0, 7);
    clear_obs();
    for (int i = 0; i < 28; i++) cycle(1'b0, 1'b0, 7);
    cycle(1'b0, 1'b1, 7);
    cycle(1'b0, 1'b0, 7);
    check_count("abort_busy_low", obs_busy_low, 1);
    for (int i = 0; i < 80; i++) cycle(1'b0, 1'b0, 7);
    check_count("abort_no_done", obs_done, 0);
    clear_obs();
    cycle(1'b1, 1'b1, 9);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 9);
    check_count("abort_start_idle", obs_busy_low, 11);
  endtask

  task automatic test_ovs();
    cycle(1'b1, 1'b0, 433);
    clear_obs();
    for (int i = 0; i < 4340; i++) cycle(1'b0, 1'b0, 433);
    check_count("ovs433_ticks", obs_tick, 160);
    check_count("ovs433_done", obs_done, 1);
    cycle(1'b1, 1'b0, 15);
    clear_obs();
    for (int i = 0; i < 160; i++) cycle(1'b0, 1'b0, 15);
    check_count("ovs15_ticks", obs_tick, 150);
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 7);
    for (int i = 0; i < 25; i++) cycle(1'b0, 1'b0, 7);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({u.busy, u.bit_mid, u.bit_end, u.ovs_tick, u.frame_done, u.bit_idx} !== 9'd0) begin
      miscompares++;
      $display("FAIL async_reset got %b%b%b%b%b/%0d exp 00000/0", u.busy, u.bit_mid,
               u.bit_end, u.ovs_tick, u.frame_done, u.bit_idx);
    end
    u.start = 1'b0; u.abort = 1'b0;
    m_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 7);
  endtask

  task automatic test_random();
    bit s, a;
    int dv;
    for (int i = 0; i < 3000; i++) begin
      s  = ($urandom_range(0, 24) == 0);
      a  = ($urandom_range(0, 149) == 0);
      dv = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8191) : $urandom_range(0, 40);
      cycle(s, a, dv);
    end
  endtask

  initial begin
    u.start  = 1'b0;
    u.abort  = 1'b0;
    u.div_in = 13'd0;
    rst_n    = 1'b0;
    clear_obs();
    test_reset();
    test_basic();
    test_clamp_latch();
    test_back_to_back();
    test_abort();
    test_ovs();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_frame_timer.md
# uart_frame_timer

Parametrised UART frame timing engine: successor to the single-rate bit-period counter. Runs on the system clock, generates per-bit mid-point and end strobes plus an oversampling tick for a full frame of `FRAME_BITS` bit periods. Supports a run-time divisor, start/abort control, a bit index and a frame-done handshake. Shared by the TX shifter (uses `bit_end`) and the RX sampler (uses `bit_mid` / `ovs_tick`).

## Interface
- `CNT_W`, 13, width of the bit-period counter and divisor.
- `DIV_DEFAULT`, 13'd433, divisor loaded at reset (bit period = div+1 clocks; 433 = 115200 bps at 50 MHz).
- `FRAME_BITS`, 10, bit periods per frame (start + 8 data + stop).
- `IDX_W`, 4, width of `bit_idx`; must hold FRAME_BITS-1.
- `OVS_LOG2`, 4, log2 of the oversampling ratio (16x).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `div_in`  in  CNT_W  divisor for the next frame; sampled only with `start`.
- `start`  in  1  single-cycle request to begin a frame.
- `abort`  in  1  synchronous cancel of the current frame.
- `busy`  out  1  frame in progress.
- `bit_mid`  out  1  one-cycle strobe at the centre of each bit.
- `bit_end`  out  1  one-cycle strobe on the last clock of each bit.
- `ovs_tick`  out  1  oversampling strobe, 2^OVS_LOG2 per bit nominal.
- `bit_idx`  out  IDX_W  index of the current bit, 0..FRAME_BITS-1.
- `frame_done`  out  1  one-cycle strobe on the last clock of the frame.

## Operation
- Registered state: `busy`, bit counter `cnt`, latched divisor `div_q`, `bit_idx`, sub counter `sub`, sub length `ovs_len`. Strobes are combinational decodes of this state, gated by `busy`.
- Reset: `busy`=0, `cnt`=0, `bit_idx`=0, `sub`=0, `div_q`=DIV_DEFAULT; all strobes 0.
- IDLE (`busy`=0): on `start`, latch `div_q` = max(`div_in`, 3) (values 0..2 clamp to 3), `ovs_len` = max((div_q+1)>>OVS_LOG2, 1), clear `cnt`/`sub`/`bit_idx`, set `busy`.
- RUN (`busy`=1): `cnt` increments each clock; wraps to 0 when `cnt`==`div_q`.
- `bit_mid` = busy && `cnt`==(`div_q`>>1). `bit_end` = busy && `cnt`==`div_q`.
- `bit_idx` increments on `bit_end`. `frame_done` = `bit_end` && `bit_idx`==FRAME_BITS-1; next cycle `busy`=0 and `bit_idx`=0.
- `sub` counts 0..ovs_len-1; `ovs_tick` = busy && `sub`==ovs_len-1 && !`bit_end`. `sub` is forced to 0 on `bit_end` to resync each bit; a truncated final sub-period yields no tick.
- `div_in` changes while busy have no effect until the next accepted `start`.
- `start` while busy is ignored, except in the `frame_done` cycle: then a new frame begins back-to-back (`busy` stays 1, new `div_q` latched, counters cleared).
- `abort` has the highest priority: `busy`=0, counters cleared next cycle, and no `frame_done`. `abort`+`start` in the same cycle: abort wins and start is dropped.
- Async reset mid-frame: immediate return to reset values.

## Timing
- Latency: `start` sampled at edge E0 → `busy`=1, `cnt`=0 after E0.
- Bit n (0-based) occupies edges E0+n·(div_q+1) .. E0+(n+1)·(div_q+1)-1.
- `bit_mid` is high after edge E0+n·(div_q+1)+(div_q>>1). `bit_end` is high after edge E0+n·(div_q+1)+div_q.
- Frame length = FRAME_BITS·(div_q+1) clocks. `busy` falls one clock after `frame_done`.
- Counter arithmetic is unsigned CNT_W with no overflow: `div_q` ≤ 2^CNT_W-1, and `cnt` never exceeds `div_q`.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `busy`, all strobes and `bit_idx` are 0. After release with no `start`, outputs stay 0 for 1000 clocks.
- Basic frame, `div_in`=9, FRAME_BITS=10, `start` at E0 → `bit_mid` after E4, E14, …, E94. `bit_end` after E9, …, E99. `frame_done` only after E99. `busy` low after E100. 10 `bit_mid` pulses in total.
- Clamp and latch: `div_in`=1 → bit period is 4 clocks. Changing `div_in` to 20 mid-frame → period remains 4 until the frame ends.
- Back-to-back: `start` with `div_in`=5 asserted in the `frame_done` cycle → `busy` never drops, and the next frame has a 6-clock bit period. A `start` mid-frame is ignored, with no change to `cnt`.
- Abort: `abort` at bit 3 → `busy`=0 next clock and no `frame_done`. `abort`+`start` in the same cycle while idle → stays idle.
- Oversampling, `div_in`=433, OVS_LOG2=4 → exactly 16 `ovs_tick` per bit, at `cnt`=26, 53, …, 431, with none at 432/433. `div_in`=15 → a tick every clock except `bit_end`, giving 15 per bit.
